// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types, defaults and round-robin pick for axis_rr_arbiter
package axis_arb_pkg;

    localparam int DEF_N_SRC     = 4;
    localparam int DEF_MAX_BURST = 16;
    localparam int MAX_SRC       = 16;

    typedef enum logic {
        IDLE,
        LOCK
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First requester after 'last', wrapping modulo n; n is the live source count.
    function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                         input logic [3:0]         last,
                                         input int                 n);
        rr_pick_t   r;
        int         cand;
        logic [3:0] c4;
        r = '0;
        for (int i = 1; i <= MAX_SRC; i++) begin
            cand = (int'(last) + i) % n;
            c4   = 4'(cand);
            if (i <= n && !r.found && req[c4]) begin
                r.found = 1'b1;
                r.idx   = c4;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry in-order register slice with registered output
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] in_tdata_i,
    input  logic             in_tvalid_i,
    output logic             in_tready_o,
    output logic [WIDTH-1:0] out_tdata_o,
    output logic             out_tvalid_o,
    input  logic             out_tready_i
);

    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic             vld0_q, vld0_d, vld1_q, vld1_d;
    logic             push, pop;

    always_comb begin
        push    = in_tvalid_i && !(vld0_q && vld1_q);
        pop     = vld0_q && out_tready_i;
        data0_d = data0_q;
        data1_d = data1_q;
        vld0_d  = vld0_q;
        vld1_d  = vld1_q;
        if (pop) begin
            data0_d = data1_q;
            vld0_d  = vld1_q;
            vld1_d  = 1'b0;
            // After the shift, the incoming beat lands in the first free slot.
            if (push) begin
                if (vld1_q) begin
                    data1_d = in_tdata_i;
                    vld1_d  = 1'b1;
                end else begin
                    data0_d = in_tdata_i;
                    vld0_d  = 1'b1;
                end
            end
        end else if (push) begin
            if (!vld0_q) begin
                data0_d = in_tdata_i;
                vld0_d  = 1'b1;
            end else begin
                data1_d = in_tdata_i;
                vld1_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data0_q <= '0;
            data1_q <= '0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
        end
    end

    assign in_tready_o  = !(vld0_q && vld1_q);
    assign out_tdata_o  = data0_q;
    assign out_tvalid_o = vld0_q;

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - N-to-1 burst round-robin AXI4S arbiter; AXIS_ARB_STATS_EN adds per-source beat counters
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_SRC     = DEF_N_SRC,
    parameter int DATA_BITS = 64,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int ID_BITS   = $clog2(N_SRC),
    parameter int BL_BITS   = $clog2(MAX_BURST) + 1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [BL_BITS-1:0]         cfg_burst_len,
    input  logic [N_SRC*DATA_BITS-1:0] s_tdata,
    input  logic [N_SRC-1:0]           s_tvalid,
    output logic [N_SRC-1:0]           s_tready,
    output logic [DATA_BITS-1:0]       m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [ID_BITS-1:0]         m_tid,
    output logic                       busy
`ifdef AXIS_ARB_STATS_EN
    ,
    output logic [N_SRC*32-1:0]        stat_beats,
    input  logic                       stat_clr
`endif
);

    arb_state_t                 state_q;
    logic [ID_BITS-1:0]         grant_q, last_grant_q;
    logic [BL_BITS-1:0]         burst_lim_q, beat_cnt_q, eff_len;
    logic [MAX_SRC-1:0]         req_pad;
    logic [3:0]                 last_pad;
    rr_pick_t                   pick;
    logic [ID_BITS-1:0]         pick_idx;
    logic                       buf_ready, g_valid, g_hs;
    logic [DATA_BITS-1:0]       g_data;
    logic [ID_BITS+DATA_BITS-1:0] buf_out;

    always_comb begin
        req_pad  = MAX_SRC'(s_tvalid);
        last_pad = 4'(last_grant_q);
        pick     = rr_pick(req_pad, last_pad, N_SRC);
        pick_idx = ID_BITS'(pick.idx);
        // Zero or oversize lengths both mean a full-size burst.
        if (cfg_burst_len == '0 || cfg_burst_len > BL_BITS'(MAX_BURST)) begin
            eff_len = BL_BITS'(MAX_BURST);
        end else begin
            eff_len = cfg_burst_len;
        end
        g_valid  = s_tvalid[grant_q];
        g_data   = s_tdata[int'(grant_q)*DATA_BITS +: DATA_BITS];
        s_tready = '0;
        if (state_q == LOCK) begin
            s_tready[grant_q] = buf_ready;
        end
        g_hs     = (state_q == LOCK) && g_valid && buf_ready;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_BITS'(N_SRC - 1);
            burst_lim_q  <= '0;
            beat_cnt_q   <= '0;
            busy         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick.found) begin
                        grant_q      <= pick_idx;
                        last_grant_q <= pick_idx;
                        burst_lim_q  <= eff_len;
                        beat_cnt_q   <= '0;
                        state_q      <= LOCK;
                        busy         <= 1'b1;
                    end
                end
                LOCK: begin
                    if (g_hs) begin
                        beat_cnt_q <= beat_cnt_q + BL_BITS'(1);
                        if ((beat_cnt_q + BL_BITS'(1)) == burst_lim_q) begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else if (!g_valid && buf_ready) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    axis_skid_buf #(
        .WIDTH(ID_BITS + DATA_BITS)
    ) u_skid (
        .clk_i       (aclk),
        .rst_ni      (aresetn),
        .in_tdata_i  ({grant_q, g_data}),
        .in_tvalid_i (g_valid && (state_q == LOCK)),
        .in_tready_o (buf_ready),
        .out_tdata_o (buf_out),
        .out_tvalid_o(m_tvalid),
        .out_tready_i(m_tready)
    );

    assign m_tid   = buf_out[ID_BITS+DATA_BITS-1:DATA_BITS];
    assign m_tdata = buf_out[DATA_BITS-1:0];

`ifdef AXIS_ARB_STATS_EN
    logic [31:0] stat_q [N_SRC];
    logic [31:0] stat_d [N_SRC];

    always_comb begin
        stat_beats = '0;
        for (int i = 0; i < N_SRC; i++) begin
            // Clear takes priority over a same-cycle handshake.
            stat_d[i] = stat_clr ? 32'd0 : stat_q[i] + {31'd0, s_tready[i] & s_tvalid[i]};
            stat_beats[i*32 +: 32] = stat_q[i];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_SRC; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) stat_q[i] <= stat_d[i];
        end
    end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - scoreboard bench for axis_rr_arbiter against a burst-level round-robin model
module tb_axis_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int MB  = 16;
    localparam int IDB = 2;
    localparam int BLB = 5;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [BLB-1:0]    cfg_burst_len = '0;
    logic [N*DW-1:0]   s_tdata = '0;
    logic [N-1:0]      s_tvalid = '0;
    logic [N-1:0]      s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic [IDB-1:0]    m_tid;
    logic              busy;
`ifdef AXIS_ARB_STATS_EN
    logic [N*32-1:0]   stat_beats;
    logic              stat_clr = 1'b0;
`endif

    axis_rr_arbiter #(.N_SRC(N), .DATA_BITS(DW), .MAX_BURST(MB)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cfg_burst_len(cfg_burst_len),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tid        (m_tid),
        .busy         (busy)
`ifdef AXIS_ARB_STATS_EN
        ,
        .stat_beats   (stat_beats),
        .stat_clr     (stat_clr)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] src_q[N][$];
    int            beat_cyc[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            occ = 0;
    logic [N-1:0]  hs_mask = '0;
    int            model_last = N - 1;
    int            mr_mode = 0;
    int            mr_cnt = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int eff_len(input int c);
        return (c == 0 || c > MB) ? MB : c;
    endfunction

    function automatic bit src_pending();
        bit p = 0;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1;
        return p;
    endfunction

    function automatic int gaps();
        if (beat_cyc.size() == 0) return -1;
        return beat_cyc[beat_cyc.size()-1] - beat_cyc[0] + 1 - beat_cyc.size();
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = src_q[i].size() > 0;
            s_tdata[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
        case (mr_mode)
            0: m_tready = 1'b1;
            1: m_tready = (mr_cnt % 3) == 0;
            2: m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
        mr_cnt++;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) if (hs_mask[i] && src_q[i].size() > 0) src_q[i].delete(0);
        drive();
    endtask

    task automatic load(input int src, input int n);
        for (int j = 0; j < n; j++) src_q[src].push_back({$urandom(), 24'(src), 8'(j)});
    endtask

    // Burst-level model: each grant takes min(burst length, beats still queued) from
    // the next source after the previous grant that has data pending.
    task automatic issue();
        int pos[N];
        int lim, p, take;
        bit found;
        lim = eff_len(int'(cfg_burst_len));
        for (int i = 0; i < N; i++) pos[i] = 0;
        p = 0;
        while (1) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && pos[(model_last + k) % N] < src_q[(model_last + k) % N].size()) begin
                    found = 1;
                    p = (model_last + k) % N;
                end
            end
            if (!found) break;
            take = src_q[p].size() - pos[p];
            if (take > lim) take = lim;
            for (int j = 0; j < take; j++) exp_q.push_back('{p, src_q[p][pos[p] + j]});
            pos[p] += take;
            model_last = p;
        end
        beat_cyc.delete();
        drive();
    endtask

    task automatic drain(input string name);
        int b = 0;
        while ((exp_q.size() > 0 || src_pending()) && b < 3000) begin
            tick();
            b++;
        end
        chk(b < 3000, name, 64'(b), 64'(3000));
        repeat (3) tick();
    endtask

    always @(negedge aclk) begin : mon
        exp_t e;
        cyc++;
        if (!aresetn) begin
            occ = 0;
            hs_mask = '0;
        end else begin
            hs_mask = s_tvalid & s_tready;
            chk(m_tvalid == (occ > 0), "m_tvalid_vs_occupancy", 64'(m_tvalid), 64'(occ > 0));
            if (occ == 2) chk(s_tready == '0, "s_tready_when_full", 64'(s_tready), 64'(0));
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", m_tdata, 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk(int'(m_tid) == e.id, "beat_tid", 64'(m_tid), 64'(e.id));
                    chk(m_tdata == e.data, "beat_tdata", m_tdata, e.data);
                end
                beat_cyc.push_back(cyc);
            end
            occ = occ + ((|hs_mask) ? 1 : 0) - ((m_tvalid && m_tready) ? 1 : 0);
        end
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        chk(m_tvalid == 1'b0, "reset_m_tvalid", 64'(m_tvalid), 64'(0));
        chk(m_tdata == '0, "reset_m_tdata", m_tdata, 64'(0));
        chk(m_tid == '0, "reset_m_tid", 64'(m_tid), 64'(0));
        chk(s_tready == '0, "reset_s_tready", 64'(s_tready), 64'(0));
        chk(busy == 1'b0, "reset_busy", 64'(busy), 64'(0));
        aresetn = 1'b1;
        tick();

        // round robin, 4-beat bursts, no back-pressure
        cfg_burst_len = 4;
        mr_mode = 0;
        for (int i = 0; i < N; i++) load(i, 8);
        issue();
        drain("drain_rr");
        chk(gaps() == 7, "rr_idle_gaps", 64'(gaps()), 64'(7));

        // source 1 goes idle after 3 beats, source 3 follows
        cfg_burst_len = 8;
        load(1, 3);
        load(3, 5);
        issue();
        drain("drain_idle_exit");
        chk(gaps() == 2, "idle_exit_gaps", 64'(gaps()), 64'(2));

        // back-pressure 1,0,0 pattern
        cfg_burst_len = 0;
        mr_mode = 1;
        for (int j = 0; j < 16; j++) src_q[2].push_back(64'(8'h10 + j));
        issue();
        drain("drain_backpressure");

        // burst length boundaries
        mr_mode = 0;
        cfg_burst_len = 0;
        load(1, 20);
        issue();
        drain("drain_bl0");
        chk(gaps() == 1, "bl0_gaps", 64'(gaps()), 64'(1));
        cfg_burst_len = 5'(MB + 1);
        load(1, 20);
        issue();
        drain("drain_bl17");
        chk(gaps() == 1, "bl17_gaps", 64'(gaps()), 64'(1));

        // randomized rounds
        for (int r = 0; r < 6; r++) begin
            cfg_burst_len = 5'($urandom_range(0, 20));
            mr_mode = $urandom_range(1, 2);
            for (int i = 0; i < N; i++) load(i, $urandom_range(0, 12));
            issue();
            drain("drain_random");
        end

        // reset mid-burst with two beats buffered
        cfg_burst_len = 8;
        mr_mode = 3;
        load(2, 6);
        issue();
        repeat (5) tick();
        chk(busy == 1'b1, "busy_in_lock", 64'(busy), 64'(1));
        aresetn = 1'b0;
        #1;
        chk(m_tvalid == 1'b0, "midreset_m_tvalid", 64'(m_tvalid), 64'(0));
        chk(s_tready == '0, "midreset_s_tready", 64'(s_tready), 64'(0));
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        model_last = N - 1;
        mr_mode = 0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        load(2, 4);
        load(0, 4);
        issue();
        drain("drain_after_reset");

`ifdef AXIS_ARB_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        tick();
        load(0, 5);
        load(3, 7);
        issue();
        drain("drain_stats");
        chk(stat_beats[0 +: 32] == 32'd5, "stat_src0", 64'(stat_beats[0 +: 32]), 64'(5));
        chk(stat_beats[96 +: 32] == 32'd7, "stat_src3", 64'(stat_beats[96 +: 32]), 64'(7));
        stat_clr = 1'b1;
        load(0, 3);
        issue();
        drain("drain_stats_clr");
        stat_clr = 1'b0;
        tick();
        chk(stat_beats[0 +: 32] == 32'd0, "stat_src0_clr", 64'(stat_beats[0 +: 32]), 64'(0));
        chk(stat_beats[96 +: 32] == 32'd0, "stat_src3_clr", 64'(stat_beats[96 +: 32]), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- N-to-1 round-robin arbiter and mux for AXI4S streams that carry tdata/tvalid/tready only, with no tlast.
- Shares one downstream AXI4S consumer (e.g. a DMA write channel or network TX) among N producers.
- Since there is no packet boundary, a grant is held for a burst of up to cfg_burst_len beats, or until the granted source goes idle.
- Output passes through a 2-entry skid register: full throughput, registered m_tdata/m_tvalid.

Parameters:
- N_SRC, 4, number of slave inputs (2..16).
- DATA_BITS, 64, tdata width of every stream.
- MAX_BURST, 16, largest beat count per grant; power of 2.
- ID_BITS, $clog2(N_SRC), width of the source-id sideband.
- BL_BITS, $clog2(MAX_BURST)+1, width of cfg_burst_len.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cfg_burst_len  in  BL_BITS  beats per grant; 0 or >MAX_BURST means MAX_BURST; sampled at grant time.
- s_tdata  in  N_SRC*DATA_BITS  slave data; slice i belongs to source i.
- s_tvalid  in  N_SRC  slave valid.
- s_tready  out  N_SRC  slave ready; one-hot or zero.
- m_tdata  out  DATA_BITS  master data (registered).
- m_tvalid  out  1  master valid (registered).
- m_tready  in  1  master ready.
- m_tid  out  ID_BITS  source index of the current m_tdata beat, aligned with m_tdata.
- busy  out  1  high while in LOCK state.

Behaviour:
- Reset (async assert, sync deassert by the environment). All of these reset together:
  - State = IDLE.
  - last_grant = N_SRC-1, so source 0 has priority first.
  - beat_cnt = 0.
  - Skid buffer empty.
  - m_tvalid = 0, m_tdata = 0, m_tid = 0, s_tready = 0, busy = 0.
- Reset mid-burst drops all held and buffered beats. No beat is replayed.
- Round-robin pick: the first i with s_tvalid[i]=1, searching last_grant+1, last_grant+2, ... with wrap modulo N_SRC.
- States:
  - IDLE:
    - If any s_tvalid is high: grant = pick; last_grant <= pick; burst_lim <= effective cfg_burst_len; beat_cnt <= 0; go to LOCK.
    - s_tready = 0 in IDLE, so granting costs 1 cycle.
  - LOCK:
    - s_tready[grant] = skid buffer not full; all other s_tready = 0.
    - Each slave handshake: increment beat_cnt and push {grant, tdata} into the skid buffer.
    - Exit to IDLE, with last_grant kept, when either:
      - a handshake makes beat_cnt reach burst_lim, or
      - s_tvalid[grant] is low in LOCK while the skid buffer is not full (source idle).
    - Exit happens on that cycle's edge. The next grant is evaluated in IDLE on the following cycle.
- Fairness: back-to-back arbitration never re-grants the same source while another source is valid, because the pick starts at last_grant+1.
- Skid buffer:
  - 2 entries. Full when 2 entries are valid.
  - m_tvalid = entry0 valid; m_tdata/m_tid come from entry0.
  - Push and pop in the same cycle keep the count unchanged and keep order.
  - With m_tready held high, sustains 1 beat/cycle.
- Latency: a beat accepted on slave cycle t appears on master at t+1 if the buffer was empty.
- Back-pressure: m_tready low for k cycles with the buffer full holds s_tready low. beat_cnt does not advance and no beat is lost.
- Source deasserting tvalid mid-burst (AXI violation only if after assertion without handshake) is treated as the idle-exit condition.
- cfg_burst_len changing during LOCK has no effect until the next grant.
- Single source valid: it is re-granted after each IDLE cycle. Steady state = burst_lim beats per burst_lim+1 cycles.

Optional Feature:
- Macro AXIS_ARB_STATS_EN.
- Defined:
  - Adds output stat_beats, N_SRC*32 bits: one free-running 32-bit counter per source, incremented on each slave handshake of that source.
  - Counters wrap at 2^32-1 -> 0, reset to 0 by aresetn.
  - Adds input stat_clr, 1 bit: synchronous clear of all counters. Clear wins over a simultaneous increment.
- Not defined: neither the port nor the counter logic exists, and the rest of the behaviour is identical.

Decomposition:
- Package axis_arb_pkg holds:
  - constants DEF_N_SRC=4 and DEF_MAX_BURST=16;
  - enum arb_state_t {IDLE, LOCK};
  - function rr_pick(req, last) returning the index and a found flag.
- One sub-module: axis_skid_buf (parameter DATA_BITS+ID_BITS). It is reusable for any AXI4S register slice.

Test Plan:
- Reset mid-burst:
  - Stimulus: source 2 streaming, m_tready=0, 2 beats buffered, then aresetn pulsed low.
  - Required: m_tvalid=0 and s_tready=0 immediately; after release, the next grant goes to source 0 if valid.
- Round-robin:
  - Stimulus: cfg_burst_len=4, all 4 sources continuously valid, m_tready=1.
  - Required: m_tid sequence is 0×4, 1×4, 2×4, 3×4, 0×4…, with 1 idle master cycle between bursts.
- Idle exit:
  - Stimulus: burst_len=8, source 1 sends 3 beats then drops tvalid, source 3 valid.
  - Required: exactly 3 beats with m_tid=1, then a grant to 3.
- Back-pressure:
  - Stimulus: single source, data 0x10..0x1F, m_tready toggling 1,0,0,1…
  - Required: output sequence 0x10..0x1F is complete and in order; s_tready is low whenever the buffer is full.
- Burst_len boundaries:
  - Stimulus: cfg_burst_len=0, then =MAX_BURST+1.
  - Required: 16 beats per grant in both cases.
- Stats (AXIS_ARB_STATS_EN):
  - Stimulus: 5 beats from source 0 and 7 from source 3, then stat_clr pulsed on a cycle with a source-0 handshake.
  - Required: counters read 5 and 7 before the clear, then 0 and 0 after it.
